ram2p_stream_fifo: RTL and testbench



---
 rtl/ram2p_fifo_pkg.sv | 11 +
 rtl/IP_Ram2P.sv | 28 ++
 rtl/ram2p_fifo_obuf.sv | 72 +++++++
 rtl/ram2p_stream_fifo.sv | 96 +++++++++
 tb/tb_ram2p_stream_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram2p_fifo_pkg.sv
// Shared sizing constants for the two-port-RAM stream FIFO slice.
package ram2p_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 116;
    localparam int ADDR_W        = $clog2(DEFAULT_DEPTH);
    localparam int RAM_COUNT_W   = $clog2(DEFAULT_DEPTH + 1);
    localparam int OBUF_COUNT_W  = 2;
    localparam int LEVEL_W       = 5;

endpackage

// File: rtl/IP_Ram2P.sv
// Behavioural model of the two-port RAM: one write port, one registered read port.
// Read data appears the cycle after enableRead and is held otherwise; contents survive reset.
module IP_Ram2P #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 116
) (
    input  logic                     clock,
    input  logic                     enableWrite,
    input  logic [$clog2(DEPTH)-1:0] addressWrite,
    input  logic [WIDTH-1:0]         writeData,
    input  logic                     enableRead,
    input  logic [$clog2(DEPTH)-1:0] addressRead,
    output logic [WIDTH-1:0]         readData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array write and registered read.
    always_ff @(posedge clock) begin
        if (enableWrite) begin
            mem[addressWrite] <= writeData;
        end
        if (enableRead) begin
            readData <= mem[addressRead];
        end
    end

endmodule

// File: rtl/ram2p_fifo_obuf.sv
// Two-entry output buffer that absorbs the RAM read latency; entry0 is always the head.
module ram2p_fifo_obuf
    import ram2p_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    capture,
    input  logic [WIDTH-1:0]        captureData,
    input  logic                    pop,
    output logic [OBUF_COUNT_W-1:0] count,
    output logic [WIDTH-1:0]        headData
);

    logic [WIDTH-1:0]        entry0;
    logic [WIDTH-1:0]        entry1;
    logic [WIDTH-1:0]        entry0Next;
    logic [WIDTH-1:0]        entry1Next;
    logic [OBUF_COUNT_W-1:0] countNext;

    assign headData = entry0;

    // Shift out the head on pop and append returning RAM data behind whatever remains.
    always_comb begin
        entry0Next = entry0;
        entry1Next = entry1;
        countNext  = count;
        case ({capture, pop})
            2'b10: begin
                if (count == 2'd0) begin
                    entry0Next = captureData;
                end else begin
                    entry1Next = captureData;
                end
                countNext = count + 2'd1;
            end
            2'b01: begin
                entry0Next = entry1;
                countNext  = count - 2'd1;
            end
            2'b11: begin
                if (count == 2'd1) begin
                    entry0Next = captureData;
                end else begin
                    entry0Next = entry1;
                    entry1Next = captureData;
                end
            end
            default: begin
            end
        endcase
    end

    // Occupancy register; reset empties the buffer and discards any returning read.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

    // Data entries need no reset because count marks which of them are meaningful.
    always_ff @(posedge clock) begin
        if (!reset) begin
            entry0 <= entry0Next;
            entry1 <= entry1Next;
        end
    end

endmodule

// File: rtl/ram2p_stream_fifo.sv
// Valid/ready FIFO around a 2-port RAM with first-word-fall-through output.
module ram2p_stream_fifo
    import ram2p_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LW    = LEVEL_W
) (
    input  logic             clockCore,
    input  logic             resetCore,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [LW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]           wrPtr;
    logic [AW-1:0]           rdPtr;
    logic [CW-1:0]           ramCount;
    logic [CW-1:0]           ramCountNext;
    logic                    inFlight;
    logic [LW-1:0]           levelReg;
    logic [OBUF_COUNT_W-1:0] obufCount;
    logic [OBUF_COUNT_W-1:0] obufCountNext;
    logic [2:0]              occupancy;
    logic                    push;
    logic                    pop;
    logic                    rdIssue;
    logic                    enableWrite;
    logic                    enableRead;
    logic [WIDTH-1:0]        readData;

    // Handshakes and read issue; the issue rule guarantees a slot for every returning read.
    always_comb begin
        inReady      = !resetCore && (ramCount != CW'(DEPTH));
        push         = inValid && inReady;
        outValid     = !resetCore && (obufCount != '0);
        pop          = outValid && outReady;
        occupancy    = {1'b0, obufCount} + {2'b00, inFlight};
        rdIssue      = !resetCore && (ramCount != '0) && (occupancy <= (3'd1 + {2'b00, pop}));
        enableWrite  = push && !resetCore;
        enableRead   = rdIssue;
        ramCountNext = ramCount + CW'(push) - CW'(rdIssue);
        obufCountNext = obufCount + OBUF_COUNT_W'(inFlight) - OBUF_COUNT_W'(pop);
        level        = resetCore ? '0 : levelReg;
    end

    // Pointers, counts and the registered level; reset drops all stored words.
    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ramCount <= '0;
            inFlight <= 1'b0;
            levelReg <= '0;
        end else begin
            wrPtr    <= wrPtr + AW'(push);
            rdPtr    <= rdPtr + AW'(rdIssue);
            ramCount <= ramCountNext;
            inFlight <= rdIssue;
            levelReg <= LW'(ramCountNext) + LW'(rdIssue) + LW'(obufCountNext);
        end
    end

    IP_Ram2P #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) ram (
        .clock        (clockCore),
        .enableWrite  (enableWrite),
        .addressWrite (wrPtr),
        .writeData    (inData),
        .enableRead   (enableRead),
        .addressRead  (rdPtr),
        .readData     (readData)
    );

    ram2p_fifo_obuf #(
        .WIDTH (WIDTH)
    ) obuf (
        .clock       (clockCore),
        .reset       (resetCore),
        .capture     (inFlight),
        .captureData (readData),
        .pop         (pop),
        .count       (obufCount),
        .headData    (outData)
    );

endmodule

// File: tb/tb_ram2p_stream_fifo.sv
// Directed self-checking bench for ram2p_stream_fifo.
module tb_ram2p_stream_fifo;

    localparam int WIDTH = 116;

    logic             clockCore = 1'b0;
    logic             resetCore;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [4:0]       level;

    int checks   = 0;
    int failures = 0;

    ram2p_stream_fifo dut (
        .clockCore (clockCore),
        .resetCore (resetCore),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .level     (level)
    );

    always #5 clockCore = ~clockCore;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clockCore);
        #1;
    endtask

    // Drive one cycle's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
        inValid  = v;
        inData   = d;
        outReady = r;
        #1;
    endtask

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] expQ[$];
        logic [WIDTH-1:0] prevData;
        logic             prevStall;
        int               firstPop;
        int               lastPop;
        int               popCount;
        int               sent;
        int               received;
        int               cyc;

        // Reset state
        resetCore = 1'b1;
        applyStimulus(1'b1, '0, 1'b0);
        tick();
        tick();
        checkOutput("reset inReady", inReady, 0);
        checkOutput("reset outValid", outValid, 0);
        checkOutput("reset level", level, 0);
        resetCore = 1'b0;

        // Single word latency
        applyStimulus(1'b1, 116'h1, 1'b1);
        checkOutput("t1 inReady after reset", inReady, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1 N+1 outValid", outValid, 0);
        checkOutput("t1 N+1 level", level, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1 N+2 outValid", outValid, 0);
        checkOutput("t1 N+2 level", level, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1 N+3 outValid", outValid, 1);
        checkOutput("t1 N+3 outData", outData, 116'h1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t1 N+4 outValid", outValid, 0);
        checkOutput("t1 N+4 level", level, 0);

        // Fill 18 words with the sink stalled
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b0);
            checkOutput("t2 inReady during fill", inReady, 1);
            tick();
        end
        applyStimulus(1'b1, WIDTH'(18), 1'b0);
        checkOutput("t2 inReady full", inReady, 0);
        checkOutput("t2 level full", level, 18);
        checkOutput("t2 head", outData, 0);
        tick();

        // Push at full with a simultaneous pop is refused, then accepted next cycle
        applyStimulus(1'b1, WIDTH'(18), 1'b1);
        checkOutput("t5 inReady on pop cycle", inReady, 0);
        checkOutput("t5 outValid", outValid, 1);
        checkOutput("t5 outData", outData, 0);
        tick();
        applyStimulus(1'b1, WIDTH'(18), 1'b1);
        checkOutput("t5 inReady next cycle", inReady, 1);
        checkOutput("t5 outData 1", outData, 1);
        tick();
        for (int k = 2; k <= 18; k++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("t2 drain outValid", outValid, 1);
            checkOutput("t2 drain outData", outData, WIDTH'(k));
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t2 empty outValid", outValid, 0);
        checkOutput("t2 empty level", level, 0);

        // Continuous streaming of 100 words
        expQ.delete();
        firstPop = -1;
        lastPop  = -1;
        popCount = 0;
        for (int c = 0; c < 110; c++) begin
            applyStimulus(c < 100, WIDTH'(1000 + c), 1'b1);
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("t3 unexpected word", outData, '1);
                end else begin
                    checkOutput("t3 order", outData, expQ.pop_front());
                end
                if (firstPop < 0) firstPop = c;
                lastPop = c;
                popCount++;
            end
            if (inValid && inReady) expQ.push_back(inData);
            tick();
        end
        checkOutput("t3 pop count", popCount, 100);
        checkOutput("t3 first pop cycle", firstPop, 3);
        checkOutput("t3 no bubbles", lastPop - firstPop, 99);

        // Random stalls on both sides with a scoreboard
        expQ.delete();
        sent      = 0;
        received  = 0;
        cyc       = 0;
        prevStall = 1'b0;
        prevData  = '0;
        while (received < 300 && cyc < 5000) begin
            applyStimulus((sent < 300) && ($urandom_range(0, 1) == 1), WIDTH'(5000 + sent),
                          $urandom_range(0, 1) == 1);
            if (prevStall) begin
                checkOutput("t4 stall outValid", outValid, 1);
                checkOutput("t4 stall outData", outData, prevData);
            end
            checkOutput("t4 level bound", level <= 5'd18, 1);
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("t4 unexpected word", outData, '1);
                end else begin
                    checkOutput("t4 order", outData, expQ.pop_front());
                end
                received++;
            end
            if (inValid && inReady) begin
                expQ.push_back(inData);
                sent++;
            end
            prevStall = outValid && !outReady;
            prevData  = outData;
            tick();
            cyc++;
        end
        checkOutput("t4 received all", received, 300);
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        tick();
        checkOutput("t4 final level", level, 0);

        // Reset with stored words and a read in flight
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, WIDTH'(200 + i), 1'b0);
            checkOutput("t6 fill inReady", inReady, 1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t6 pop head", outData, 200);
        tick();
        resetCore = 1'b1;
        applyStimulus(1'b1, WIDTH'(999), 1'b0);
        checkOutput("t6 reset inReady", inReady, 0);
        checkOutput("t6 reset outValid", outValid, 0);
        checkOutput("t6 reset level", level, 0);
        tick();
        resetCore = 1'b0;
        applyStimulus(1'b1, 116'hABC, 1'b1);
        checkOutput("t6 post inReady", inReady, 1);
        checkOutput("t6 post outValid", outValid, 0);
        checkOutput("t6 post level", level, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t6 N+1 outValid", outValid, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t6 N+2 outValid", outValid, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t6 N+3 outValid", outValid, 1);
        checkOutput("t6 N+3 outData", outData, 116'hABC);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("t6 after outValid", outValid, 0);
        checkOutput("t6 after level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
